memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Memory stage of the 64-bit pipeline; sits directly downstream of the execute/memory pipeline register and consumes its data and control outputs.
- Performs data-memory loads/stores over a req/ack port, stalling upstream while an access is outstanding.
- Holds the architectural NZCV flag register.
- Produces a registered writeback packet (data, destination register, write enable) for the writeback stage.

Parameters:
- DATA_W, 64, datapath width.
- REG_AW, 5, register-file address width.
- TIMEOUT, 16, max cycles waiting for dmem_ack before fault; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream packet valid.
- alu_result  in  [0:63]  ALU result / memory address.
- operand_b  in  [0:63]  store data.
- regwrite  in  1  instruction writes the register file.
- write_addr  in  [0:4]  destination register.
- memwrite  in  1  store.
- memtoreg  in  1  load.
- setflags  in  1  update NZCV.
- flags  in  [0:3]  NZCV from ALU; N is bit 0, V is bit 3.
- stall  out  1  upstream must hold its outputs.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  [0:63]  access address.
- dmem_wdata  out  [0:63]  write data.
- dmem_rdata  in  [0:63]  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- wb_valid  out  1  writeback packet valid, one-cycle pulse per instruction.
- wb_regwrite  out  1  writeback register enable.
- wb_addr  out  [0:4]  writeback destination.
- wb_data  out  [0:63]  writeback value.
- flag_reg  out  [0:3]  architectural NZCV.
- mem_fault  out  1  one-cycle fault pulse.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, timeout counter 0. All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, flag_reg=0000, mem_fault.
- An instruction is accepted when in_valid=1 and stall=0. stall = (state==ACCESS), combinational from state only.
- Flags: on acceptance with setflags=1, flag_reg takes flags at that edge, regardless of memory outcome.
- Non-memory instruction (memwrite=0, memtoreg=0): next edge wb_valid=1, wb_data=alu_result, wb_addr=write_addr, wb_regwrite=regwrite. Latency 1.
- Illegal (memwrite=1 and memtoreg=1) or misaligned (alu_result[61:63]!=0) memory op:
  - No request issued.
  - Next edge: mem_fault=1, wb_valid=0, wb_regwrite=0.
- Legal memory op, IDLE->ACCESS:
  - At the acceptance edge: dmem_req=1, dmem_we=memwrite, dmem_addr=alu_result, dmem_wdata=operand_b; wb_addr and wb_regwrite are captured.
  - Request signals stay stable until completion.
- In ACCESS:
  - Counter increments each cycle without ack.
  - dmem_ack=1 -> next edge: dmem_req=0, state IDLE, wb_valid=1.
    - Load: wb_data=dmem_rdata.
    - Store: wb_data=alu_result captured at acceptance, wb_regwrite=0.
  - No ack and counter==TIMEOUT-1 (TIMEOUT>0) -> next edge: dmem_req=0, mem_fault=1, wb_valid=0, state IDLE, counter 0.
  - Ack and timeout in the same cycle: ack wins.
- States: IDLE, ACCESS only. Back-to-back accesses take at least 2 cycles each, because stall is high for the whole ACCESS state.
- wb_valid and mem_fault are pulses: cleared every cycle unless set by the events above.
- dmem_ack while IDLE is ignored.
- Reset mid-ACCESS: dmem_req drops immediately and asynchronously; the in-flight access is abandoned with no wb_valid and no fault.

Decomposition:
- Shared package cpu_pkg holds:
  - mem_state_t enum {IDLE, ACCESS}.
  - Constants DATA_W=64, REG_AW=5.
  - Flag-bit indices FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3.
- One sub-module, dmem_access_ctrl: owns the IDLE/ACCESS FSM, timeout counter, request holding registers and fault generation.
- memory_stage keeps acceptance logic, flag register and writeback registers.

Test Plan:
- Reset, then ALU op alu_result=0x1234, regwrite=1, write_addr=7 -> 1 cycle later wb_valid=1, wb_data=0x1234, wb_addr=7; stall never asserted.
- Load at 0x100, dmem_ack after 3 cycles with rdata=0xDEADBEEF -> stall=1 for 4 cycles, dmem_addr=0x100, dmem_we=0; then wb_valid=1, wb_data=0xDEADBEEF.
- Store 0xAA to 0x208, immediate ack -> dmem_we=1, dmem_wdata=0xAA for 1 cycle; wb_valid=1, wb_regwrite=0.
- Load with no ack, TIMEOUT=16 -> mem_fault pulses exactly 16 cycles after the request; dmem_req=0 afterwards; wb_valid stays 0. Repeat with ack on cycle 16: ack wins, no fault.
- Misaligned load at 0x104 with setflags=1, flags=1010 -> no dmem_req, mem_fault pulse, flag_reg=1010.
- Assert rst=0 mid-ACCESS -> dmem_req, stall and flag_reg go 0 without a clock edge; after release, an ALU op completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and constants for the 64-bit pipeline stages.
//             Provides the data-memory FSM state encoding, datapath and
//             register-file widths, NZCV flag bit positions, and a small
//             alignment helper.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int DATA_W = 64;
   localparam int REG_AW = 5;

   // NZCV flag positions within a [0:3] flag vector (N is the MSB, bit 0)
   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   // Data-memory accesses are 64-bit words, so the three address LSBs
   // must be zero.
   function automatic logic dword_misaligned(input logic [2:0] low_bits);
      return (low_bits != 3'b000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl
//  Purpose  : Data-memory access controller. Owns the IDLE/ACCESS FSM, the
//             ack timeout counter, the request holding registers and the
//             fault pulse.
//  Ports    :
//    clk            in   clock, rising edge
//    rst            in   asynchronous active-low reset
//    i_start        in   accept a legal memory op this cycle (IDLE only)
//    i_bad          in   accept an illegal/misaligned memory op (IDLE only)
//    i_we           in   1 = store
//    i_addr         in   access address
//    i_wdata        in   store data
//    i_dmem_ack     in   memory access complete
//    o_busy         out  FSM is in ACCESS (combinational from state)
//    o_done         out  ack seen while in ACCESS (completes next edge)
//    o_timeout      out  timeout expiry this cycle (faults next edge)
//    o_dmem_req     out  memory request
//    o_dmem_we      out  memory write enable
//    o_dmem_addr    out  memory address
//    o_dmem_wdata   out  memory write data
//    o_fault        out  one-cycle fault pulse
//  Revision : 1.0  initial release
// ============================================================================
module dmem_access_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_bad,
   input  logic              i_we,
   input  logic [0:DATA_W-1] i_addr,
   input  logic [0:DATA_W-1] i_wdata,
   input  logic              i_dmem_ack,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [0:DATA_W-1] o_dmem_addr,
   output logic [0:DATA_W-1] o_dmem_wdata,
   output logic              o_fault
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] C_TMAX = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   mem_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req;
   logic              r_we;
   logic [0:DATA_W-1] r_addr;
   logic [0:DATA_W-1] r_wdata;
   logic              r_fault;
   logic              w_tmo_hit;

   generate
      if (TIMEOUT > 0) begin : g_tmo_on
         assign w_tmo_hit = (r_cnt == C_TMAX);
      end else begin : g_tmo_off
         assign w_tmo_hit = 1'b0;
      end
   endgenerate

   assign o_busy    = (r_state == ACCESS);
   assign o_done    = (r_state == ACCESS) && i_dmem_ack;
   // Ack has priority over an expiring timeout in the same cycle.
   assign o_timeout = (r_state == ACCESS) && !i_dmem_ack && w_tmo_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (i_bad) begin
                  r_fault <= 1'b1;
               end else if (i_start) begin
                  r_state <= ACCESS;
                  r_req   <= 1'b1;
                  r_we    <= i_we;
                  r_addr  <= i_addr;
                  r_wdata <= i_wdata;
               end
            end
            ACCESS: begin
               if (i_dmem_ack) begin
                  r_req   <= 1'b0;
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_tmo_hit) begin
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_dmem_req   = r_req;
   assign o_dmem_we    = r_we;
   assign o_dmem_addr  = r_addr;
   assign o_dmem_wdata = r_wdata;
   assign o_fault      = r_fault;

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module   : memory_stage
//  Purpose  : Memory stage of the 64-bit pipeline. Accepts packets from the
//             execute/memory register, runs loads/stores over a req/ack
//             data-memory port (stalling upstream while busy), holds the
//             NZCV flag register and emits a registered writeback packet.
//  Ports    :
//    clk, rst                  clock / asynchronous active-low reset
//    in_valid                  upstream packet valid
//    alu_result, operand_b     ALU result (address) / store data
//    regwrite, write_addr      destination enable / register
//    memwrite, memtoreg        store / load
//    setflags, flags           NZCV update enable / value
//    stall                     upstream must hold
//    dmem_req/we/addr/wdata    data-memory request
//    dmem_rdata, dmem_ack      data-memory response
//    wb_valid/regwrite/addr/data  writeback packet
//    flag_reg                  architectural NZCV
//    mem_fault                 one-cycle fault pulse
//  Revision : 1.0  initial release
// ============================================================================
module memory_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [0:DATA_W-1] alu_result,
   input  logic [0:DATA_W-1] operand_b,
   input  logic              regwrite,
   input  logic [0:REG_AW-1] write_addr,
   input  logic              memwrite,
   input  logic              memtoreg,
   input  logic              setflags,
   input  logic [0:3]        flags,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [0:DATA_W-1] dmem_addr,
   output logic [0:DATA_W-1] dmem_wdata,
   input  logic [0:DATA_W-1] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [0:REG_AW-1] wb_addr,
   output logic [0:DATA_W-1] wb_data,
   output logic [0:3]        flag_reg,
   output logic              mem_fault
);

   logic w_accept;
   logic w_memop;
   logic w_illegal;
   logic w_misal;
   logic w_bad;
   logic w_start;
   logic w_busy;
   logic w_done;
   logic w_timeout;

   logic              r_wb_valid;
   logic              r_wb_regwrite;
   logic [0:REG_AW-1] r_wb_addr;
   logic [0:DATA_W-1] r_wb_data;
   logic [0:3]        r_flag_reg;

   assign stall     = w_busy;
   assign w_accept  = in_valid && !w_busy;
   assign w_memop   = memwrite || memtoreg;
   assign w_illegal = memwrite && memtoreg;
   assign w_misal   = dword_misaligned(alu_result[DATA_W-3:DATA_W-1]);
   assign w_bad     = w_accept && w_memop && (w_illegal || w_misal);
   assign w_start   = w_accept && w_memop && !w_illegal && !w_misal;

   dmem_access_ctrl #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .i_start      (w_start),
      .i_bad        (w_bad),
      .i_we         (memwrite),
      .i_addr       (alu_result),
      .i_wdata      (operand_b),
      .i_dmem_ack   (dmem_ack),
      .o_busy       (w_busy),
      .o_done       (w_done),
      .o_timeout    (w_timeout),
      .o_dmem_req   (dmem_req),
      .o_dmem_we    (dmem_we),
      .o_dmem_addr  (dmem_addr),
      .o_dmem_wdata (dmem_wdata),
      .o_fault      (mem_fault)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flag_reg <= '0;
      end else if (w_accept && setflags) begin
         r_flag_reg <= flags;
      end
   end

   // Acceptance and completion are mutually exclusive: completion only
   // happens in ACCESS, where stall blocks acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_valid    <= 1'b0;
         r_wb_regwrite <= 1'b0;
         r_wb_addr     <= '0;
         r_wb_data     <= '0;
      end else begin
         r_wb_valid <= 1'b0;
         if (w_accept && !w_memop) begin
            r_wb_valid    <= 1'b1;
            r_wb_data     <= alu_result;
            r_wb_addr     <= write_addr;
            r_wb_regwrite <= regwrite;
         end else if (w_bad) begin
            r_wb_regwrite <= 1'b0;
         end else if (w_start) begin
            r_wb_addr     <= write_addr;
            r_wb_regwrite <= regwrite;
         end else if (w_done) begin
            r_wb_valid <= 1'b1;
            // The held request address is the ALU result captured at
            // acceptance, which is what a store writes back.
            if (dmem_we) begin
               r_wb_data     <= dmem_addr;
               r_wb_regwrite <= 1'b0;
            end else begin
               r_wb_data <= dmem_rdata;
            end
         end else if (w_timeout) begin
            r_wb_regwrite <= 1'b0;
         end
      end
   end

   assign wb_valid    = r_wb_valid;
   assign wb_regwrite = r_wb_regwrite;
   assign wb_addr     = r_wb_addr;
   assign wb_data     = r_wb_data;
   assign flag_reg    = r_flag_reg;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_stage
//  Purpose  : Directed self-checking bench for memory_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [0:63] alu_result;
   logic [0:63] operand_b;
   logic        regwrite;
   logic [0:4]  write_addr;
   logic        memwrite;
   logic        memtoreg;
   logic        setflags;
   logic [0:3]  flags;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [0:63] dmem_addr;
   logic [0:63] dmem_wdata;
   logic [0:63] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_regwrite;
   logic [0:4]  wb_addr;
   logic [0:63] wb_data;
   logic [0:3]  flag_reg;
   logic        mem_fault;

   int n_total = 0;
   int n_bad   = 0;

   memory_stage #(
      .DATA_W  (64),
      .REG_AW  (5),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .alu_result  (alu_result),
      .operand_b   (operand_b),
      .regwrite    (regwrite),
      .write_addr  (write_addr),
      .memwrite    (memwrite),
      .memtoreg    (memtoreg),
      .setflags    (setflags),
      .flags       (flags),
      .stall       (stall),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_ack    (dmem_ack),
      .wb_valid    (wb_valid),
      .wb_regwrite (wb_regwrite),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .flag_reg    (flag_reg),
      .mem_fault   (mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      memwrite   = 1'b0;
      memtoreg   = 1'b0;
      setflags   = 1'b0;
      regwrite   = 1'b0;
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic rw,
                        input logic [4:0] wa, input logic mw, input logic mr,
                        input logic sf, input logic [3:0] fl);
      in_valid   = 1'b1;
      alu_result = a;
      operand_b  = b;
      regwrite   = rw;
      write_addr = wa;
      memwrite   = mw;
      memtoreg   = mr;
      setflags   = sf;
      flags      = fl;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b0;
      alu_result = '0;
      operand_b  = '0;
      write_addr = '0;
      flags      = '0;
      dmem_rdata = '0;
      dmem_ack   = 1'b0;
      idle_inputs();
      #1;
      // reset state
      chk("rst_req",      dmem_req,    0);
      chk("rst_stall",    stall,       0);
      chk("rst_wbvalid",  wb_valid,    0);
      chk("rst_wbdata",   wb_data,     0);
      chk("rst_flags",    flag_reg,    0);
      chk("rst_fault",    mem_fault,   0);
      chk("rst_addr",     dmem_addr,   0);
      #13 rst = 1'b1;
      tick();

      // ALU op, latency 1
      drive(64'h1234, 64'h0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 4'b0000);
      chk("alu_stall", stall, 0);
      tick();
      idle_inputs();
      chk("alu_wbvalid", wb_valid,    1);
      chk("alu_wbdata",  wb_data,     64'h1234);
      chk("alu_wbaddr",  wb_addr,     7);
      chk("alu_wbrw",    wb_regwrite, 1);
      chk("alu_stall2",  stall,       0);
      tick();
      chk("alu_pulse",   wb_valid,    0);

      // ack while IDLE is ignored
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("idle_ack_wb", wb_valid, 0);
      chk("idle_ack_req", dmem_req, 0);

      // load at 0x100, ack after 3 cycles
      drive(64'h100, 64'h0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 4'b0000);
      tick();
      idle_inputs();
      chk("ld_req",   dmem_req,  1);
      chk("ld_we",    dmem_we,   0);
      chk("ld_addr",  dmem_addr, 64'h100);
      chk("ld_stall0", stall,    1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("ld_stall_n", stall, 1);
         chk("ld_wb_quiet", wb_valid, 0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 64'hDEADBEEF;
      tick();
      dmem_ack = 1'b0;
      chk("ld_stall_end", stall,       0);
      chk("ld_req_end",   dmem_req,    0);
      chk("ld_wbvalid",   wb_valid,    1);
      chk("ld_wbdata",    wb_data,     64'hDEADBEEF);
      chk("ld_wbaddr",    wb_addr,     3);
      chk("ld_wbrw",      wb_regwrite, 1);
      tick();
      chk("ld_pulse", wb_valid, 0);

      // store 0xAA to 0x208, immediate ack; regwrite=1 must be suppressed
      drive(64'h208, 64'hAA, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      idle_inputs();
      chk("st_req",   dmem_req,   1);
      chk("st_we",    dmem_we,    1);
      chk("st_wdata", dmem_wdata, 64'hAA);
      chk("st_addr",  dmem_addr,  64'h208);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("st_req_end", dmem_req,    0);
      chk("st_wbvalid", wb_valid,    1);
      chk("st_wbrw",    wb_regwrite, 0);
      chk("st_wbdata",  wb_data,     64'h208);
      tick();

      // load with no ack: fault 16 cycles after request
      drive(64'h300, 64'h0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 4'b0000);
      tick();
      idle_inputs();
      chk("to_req", dmem_req, 1);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("to_nofault", mem_fault, 0);
      end
      tick();
      chk("to_fault",   mem_fault, 1);
      chk("to_req_end", dmem_req,  0);
      chk("to_wbvalid", wb_valid,  0);
      chk("to_stall",   stall,     0);
      tick();
      chk("to_pulse",   mem_fault, 0);
      chk("to_wbv2",    wb_valid,  0);

      // ack on cycle 16 beats timeout
      drive(64'h308, 64'h0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 4'b0000);
      tick();
      idle_inputs();
      for (int i = 1; i <= 15; i++) tick();
      chk("race_stall", stall, 1);
      dmem_ack   = 1'b1;
      dmem_rdata = 64'h0123456789ABCDEF;
      tick();
      dmem_ack = 1'b0;
      chk("race_fault",   mem_fault, 0);
      chk("race_wbvalid", wb_valid,  1);
      chk("race_wbdata",  wb_data,   64'h0123456789ABCDEF);
      chk("race_req",     dmem_req,  0);
      tick();

      // misaligned load with flag update
      drive(64'h104, 64'h0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, 4'b1010);
      tick();
      idle_inputs();
      chk("mis_req",     dmem_req,    0);
      chk("mis_fault",   mem_fault,   1);
      chk("mis_wbvalid", wb_valid,    0);
      chk("mis_wbrw",    wb_regwrite, 0);
      chk("mis_flags",   flag_reg,    4'b1010);
      chk("mis_stall",   stall,       0);
      tick();
      chk("mis_pulse",   mem_fault,   0);

      // illegal load+store, aligned
      drive(64'h400, 64'h0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 4'b0000);
      tick();
      idle_inputs();
      chk("ill_req",   dmem_req,  0);
      chk("ill_fault", mem_fault, 1);
      chk("ill_flags", flag_reg,  4'b1010);
      tick();

      // reset mid-ACCESS
      drive(64'h500, 64'h0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 4'b0110);
      tick();
      idle_inputs();
      chk("mr_req_pre",   dmem_req, 1);
      chk("mr_flags_pre", flag_reg, 4'b0110);
      #2 rst = 1'b0;
      #1;
      chk("mr_req",   dmem_req, 0);
      chk("mr_stall", stall,    0);
      chk("mr_flags", flag_reg, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("mr_nowb",    wb_valid,  0);
      chk("mr_nofault", mem_fault, 0);
      drive(64'h55, 64'h0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 4'b0000);
      tick();
      idle_inputs();
      chk("mr_alu_wbv",  wb_valid, 1);
      chk("mr_alu_data", wb_data,  64'h55);
      chk("mr_alu_addr", wb_addr,  12);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
